// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle for the multi-cycle ALU.
//   master: upstream execute stage; drives in_valid/a/b/alu_control and out_ready.
//   slave : the ALU; drives in_ready, out_valid, result and zero.
//   in_valid/in_ready    accept handshake for one operation
//   a, b, alu_control    operands and 4-bit opcode, sampled at accept
//   out_valid/out_ready  result handshake; result/zero held while out_valid
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, a, b, alu_control, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, a, b, alu_control, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result and valid/ready handshakes.
// Single-cycle ops (add..sltu) finish in one cycle. mul/mulhu use an iterative
// shift-add and div/divu/rem/remu use a restoring divider. Both take WIDTH
// steps. Divide-by-zero and signed MIN/-1 are resolved immediately.
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    alu_mc_if slave modport (operands in, result out)
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             hiSel_q, hiSel_d;
  logic             negQuo_q, negQuo_d;
  logic             negRem_q, negRem_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] baseRes;
  logic [WIDTH-1:0] minVal;
  logic             divSigned;
  logic             divIsRem;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH-1:0] mulRes;
  logic [WIDTH:0]   divShift, divDiff;
  logic             divGe;
  logic [WIDTH-1:0] newRem, newQuo;
  logic [WIDTH-1:0] divRes;

  assign shamt     = bus.b[SHW-1:0];
  assign minVal    = {1'b1, {(WIDTH-1){1'b0}}};
  // Opcodes 1100/1110 are the signed divide pair; bit 1 selects remainder.
  assign divSigned = ~bus.alu_control[0];
  assign divIsRem  = bus.alu_control[1];
  assign magA      = (divSigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign magB      = (divSigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Single-cycle operations, evaluated straight off the input operands.
  always_comb begin
    baseRes = '0;
    unique case (bus.alu_control)
      4'b0000: baseRes = bus.a + bus.b;
      4'b0001: baseRes = bus.a - bus.b;
      4'b0010: baseRes = bus.a & bus.b;
      4'b0011: baseRes = bus.a | bus.b;
      4'b0100: baseRes = bus.a ^ bus.b;
      4'b0101: baseRes = bus.a << shamt;
      4'b0110: baseRes = bus.a >> shamt;
      4'b0111: baseRes = $unsigned($signed(bus.a) >>> shamt);
      4'b1000: baseRes = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b1001: baseRes = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      default: baseRes = '0;
    endcase
  end

  // One shift-add step. The multiplicand is added into the upper half when
  // the current multiplier bit is set. Then the whole accumulator moves right,
  // so after WIDTH steps it holds the full 2*WIDTH product.
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mulNext = {mulSum, acc_q[WIDTH-1:1]};
  assign mulRes  = hiSel_q ? mulNext[2*WIDTH-1:WIDTH] : mulNext[WIDTH-1:0];

  // One restoring-divide step on magnitudes. The upper half is the partial
  // remainder. The lower half starts as the dividend and fills with quotient bits.
  assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opnd_q};
  assign divGe    = ~divDiff[WIDTH];
  assign newRem   = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
  assign newQuo   = {acc_q[WIDTH-2:0], divGe};
  assign divRes   = hiSel_q ? (negRem_q ? -newRem : newRem)
                            : (negQuo_q ? -newQuo : newQuo);

  // Next-state and datapath control. zero always tracks the value that is
  // about to be registered as result, never the working accumulator.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    mplier_d = mplier_q;
    hiSel_d  = hiSel_q;
    negQuo_d = negQuo_q;
    negRem_d = negRem_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (!bus.alu_control[3] || bus.alu_control[3:1] == 3'b100) begin
            result_d = baseRes;
            state_d  = DONE;
          end else if (bus.alu_control[3:1] == 3'b101) begin
            acc_d    = '0;
            opnd_d   = bus.a;
            mplier_d = bus.b;
            hiSel_d  = bus.alu_control[0];
            cnt_d    = (SHW+1)'(WIDTH);
            state_d  = MUL;
          end else if (bus.b == '0) begin
            result_d = divIsRem ? bus.a : {WIDTH{1'b1}};
            state_d  = DONE;
          end else if (divSigned && bus.a == minVal && bus.b == {WIDTH{1'b1}}) begin
            result_d = divIsRem ? {WIDTH{1'b0}} : minVal;
            state_d  = DONE;
          end else begin
            acc_d    = {{WIDTH{1'b0}}, magA};
            opnd_d   = magB;
            hiSel_d  = divIsRem;
            negQuo_d = divSigned && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negRem_d = divSigned && bus.a[WIDTH-1];
            cnt_d    = (SHW+1)'(WIDTH);
            state_d  = DIV;
          end
        end
      end
      MUL: begin
        acc_d    = mulNext;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - (SHW+1)'(1);
        if (cnt_q == (SHW+1)'(1)) begin
          result_d = mulRes;
          state_d  = DONE;
        end
      end
      DIV: begin
        acc_d = {newRem, newQuo};
        cnt_d = cnt_q - (SHW+1)'(1);
        if (cnt_q == (SHW+1)'(1)) begin
          result_d = divRes;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  // State and datapath registers. Reset drops any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      mplier_q <= '0;
      hiSel_q  <= 1'b0;
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      mplier_q <= mplier_d;
      hiSel_q  <= hiSel_d;
      negQuo_q <= negQuo_d;
      negRem_q <= negRem_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc. Directed cases plus randomized
// operations are compared against a plain-arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  int   totalChecks = 0;
  int   badChecks = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference result computed from the opcode table with ordinary arithmetic.
  function automatic logic [W-1:0] refResult(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy;
    longint unsigned prod;
    sx   = int'(x);
    sy   = int'(y);
    prod = longint'({32'b0, x}) * longint'({32'b0, y});
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return x << y[4:0];
      4'd6:  return x >> y[4:0];
      4'd7:  return W'(sx >>> y[4:0]);
      4'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd9:  return (x < y) ? 32'd1 : 32'd0;
      4'd10: return prod[31:0];
      4'd11: return prod[63:32];
      4'd12: if (y == 0) return '1; else if (x == MINV && y == '1) return MINV; else return W'(sx / sy);
      4'd13: if (y == 0) return '1; else return x / y;
      4'd14: if (y == 0) return x; else if (x == MINV && y == '1) return '0; else return W'(sx % sy);
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction

  // Expected accept-to-out_valid latency in cycles.
  function automatic int refLatency(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    if (op == 4'd10 || op == 4'd11) return W + 1;
    if (op >= 4'd12) begin
      if (y == 0) return 1;
      if ((op == 4'd12 || op == 4'd14) && x == MINV && y == '1) return 1;
      return W + 1;
    end
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one operation, scramble the inputs after accept, wait (bounded)
  // for the result, check it, then retire it with a one-cycle out_ready.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] expRes;
    int lat;
    expRes = refResult(op, x, y);
    @(negedge clk);
    checkOutput({tag, " in_ready_pre"}, W'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.a           = x;
    bus.b           = y;
    bus.alu_control = op;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.a           = $urandom;
    bus.b           = $urandom;
    bus.alu_control = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " out_valid"}, W'(bus.out_valid), 32'd1);
    checkOutput({tag, " latency"}, W'(lat), W'(refLatency(op, x, y)));
    checkOutput({tag, " result"}, bus.result, expRes);
    checkOutput({tag, " zero"}, W'(bus.zero), W'(expRes == 0));
    checkOutput({tag, " in_ready_busy"}, W'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, " in_ready_post"}, W'(bus.in_ready), 32'd1);
    checkOutput({tag, " out_valid_post"}, W'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] op;
    logic [W-1:0] x, y;
    int waitCount;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.alu_control = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", W'(bus.in_ready), 32'd1);
    checkOutput("reset out_valid", W'(bus.out_valid), 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    checkOutput("reset zero", W'(bus.zero), 32'd1);

    applyStimulus("add wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    applyStimulus("sra", 4'd7, 32'h8000_0000, 32'h21);
    applyStimulus("mul", 4'd10, 32'hFFFF_FFFF, 32'd2);
    applyStimulus("mulhu", 4'd11, 32'hFFFF_FFFF, 32'd2);
    applyStimulus("div neg", 4'd12, -32'sd7, 32'd2);
    applyStimulus("rem neg", 4'd14, -32'sd7, 32'd2);
    applyStimulus("divu by0", 4'd13, 32'd7, 32'd0);
    applyStimulus("remu by0", 4'd15, 32'd7, 32'd0);
    applyStimulus("div ovf", 4'd12, MINV, 32'hFFFF_FFFF);
    applyStimulus("rem ovf", 4'd14, MINV, 32'hFFFF_FFFF);
    applyStimulus("slt", 4'd8, 32'hFFFF_FFFF, 32'd1);
    applyStimulus("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1);

    // Back-pressure: result must sit still while a competing request is ignored.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = -32'sd7; bus.b = 32'd2; bus.alu_control = 4'd12;
    @(negedge clk);
    bus.in_valid = 1'b0;
    waitCount = 1;
    while (!bus.out_valid && waitCount < 100) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput("bp out_valid", W'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.alu_control = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp hold result", bus.result, 32'hFFFF_FFFD);
      checkOutput("bp hold in_ready", W'(bus.in_ready), 32'd0);
      checkOutput("bp hold out_valid", W'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("bp release in_ready", W'(bus.in_ready), 32'd1);
    @(negedge clk);
    checkOutput("bp ignored op", W'(bus.out_valid), 32'd0);

    // Reset in the middle of a multiply drops it entirely.
    bus.in_valid = 1'b1; bus.a = 32'd12345; bus.b = 32'd678; bus.alu_control = 4'd10;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid-mul busy", W'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort out_valid", W'(bus.out_valid), 32'd0);
    checkOutput("abort result", bus.result, 32'd0);
    checkOutput("abort zero", W'(bus.zero), 32'd1);
    checkOutput("abort in_ready", W'(bus.in_ready), 32'd1);
    applyStimulus("add after abort", 4'd0, 32'd3, 32'd4);

    // Randomized operations with a bias toward the divide corner cases.
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: begin x = $urandom; y = '0; end
        1: begin x = MINV; y = '1; end
        2: begin x = W'($urandom_range(0, 40)) - 32'd20; y = W'($urandom_range(0, 10)) - 32'd5; end
        default: begin x = $urandom; y = $urandom; end
      endcase
      applyStimulus("random", op, x, y);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the processor's single-cycle combinational ALU.
- Keeps the eight base operations on the same 3-bit encodings, now under a 4-bit opcode.
- Adds set-less-than, iterative shift-add multiply and restoring divide/remainder.
- All results are registered and move over a valid/ready handshake, so the core's execute stage can stall on long operations.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, minimum 8.
- SHW, $clog2(WIDTH), derived (localparam); number of shift-amount bits taken from b.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a, b and alu_control are valid this cycle.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_control  input  4  opcode (see Behaviour).
- out_valid  output  1  result and zero are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered; high when result == 0.

Behaviour:
- Opcodes:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor.
  - 0101 sll, 0110 srl, 0111 sra; shift amount is b[SHW-1:0] for all three.
  - 1000 slt (signed) and 1001 sltu (unsigned); result is 1 or 0, zero-extended.
  - 1010 mul, low WIDTH bits of the product.
  - 1011 mulhu, high WIDTH bits of the unsigned 2*WIDTH product.
  - 1100 div (signed); 1101 divu; 1110 rem (signed); 1111 remu.
- Accept: an operation is accepted on a cycle with in_valid && in_ready. Operands and opcode are captured at accept, so input changes afterwards have no effect.
- FSM states: IDLE, MUL, DIV, DONE. in_ready = (state == IDLE).
- IDLE on accept:
  - Opcodes 0000-1001 compute combinationally, register result/zero, and go to DONE. out_valid rises the next cycle (latency 1).
  - mul/mulhu go to MUL and load a 2*WIDTH accumulator = 0. A 6-bit/SHW+1 counter is set to WIDTH.
  - div/divu/rem/remu with b == 0 go straight to DONE:
    - div/divu: result = all ones.
    - rem/remu: result = a.
  - Signed div/rem with a == MIN and b == all ones go straight to DONE:
    - div: result = MIN.
    - rem: result = 0.
  - All other div/rem go to DIV. Operands are converted to magnitudes; the quotient and remainder signs are recorded.
- MUL: one shift-add step per cycle for WIDTH cycles, then DONE. Accept at cycle N gives out_valid at N+WIDTH+1.
- DIV: one restoring step per cycle for WIDTH cycles, then sign fix-up. Signed results:
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of a.
  - Then DONE, with out_valid at N+WIDTH+1.
- DONE:
  - out_valid = 1; result and zero are held stable.
  - Leave for IDLE on out_ready. The next op can be accepted the cycle after the handshake; there is no same-cycle accept.
- Back-pressure: out_ready low holds DONE indefinitely with no change to result.
- in_valid while busy (in_ready = 0) is ignored. Upstream must hold the operation until accepted.
- reset:
  - Values: state = IDLE, out_valid = 0, result = 0, zero = 1, counter = 0, in_ready = 1 the cycle after reset deasserts.
  - Reset in MUL/DIV/DONE aborts the operation and drops the pending result.
- Wrap: add, sub and mul wrap modulo 2^WIDTH, with no overflow flag.
- Shift amount bits of b above SHW are ignored.
- zero is always derived from the registered result, never from the accumulator.

Test Plan:
- Reset, then add a=0xFFFFFFFF, b=1 -> out_valid 1 cycle after accept; result=0, zero=1. sra a=0x80000000, b=0x21 -> result=0xC0000000.
- mul a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFE exactly 33 cycles after accept. mulhu with the same operands -> result=1.
- div a=-7, b=2 -> result=-3 (0xFFFFFFFD); rem -> -1. divu a=7, b=0 -> all ones after 1 cycle. remu a=7, b=0 -> 7.
- div a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, 1-cycle latency. rem with the same operands -> 0, zero=1.
- Hold out_ready=0 for 10 cycles after div completes -> result stable, in_ready=0, and a new in_valid is ignored. Raise out_ready -> in_ready=1 the next cycle.
- Assert reset mid-MUL at iteration 5 -> out_valid=0, result=0, in_ready=1 the next cycle. A following add 3+4 returns 7.
